// File: rtl/button_conditioner.sv
// Multi-channel button synchroniser, debouncer and edge/auto-repeat pulse generator; outputs move on edge STABLE_CYCLES+3 after a level change.
// Auto-repeat exists only when BUTTON_AUTOREPEAT_EN is defined; otherwise repeat_mask_in is ignored.
module button_conditioner #(
    parameter int NUM_CH        = 5,
    parameter int STABLE_CYCLES = 1000000,
    parameter int REPEAT_DELAY  = 12500000,
    parameter int REPEAT_PERIOD = 2500000
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [NUM_CH-1:0] noisy_in,
    input  logic [NUM_CH-1:0] repeat_mask_in,
    output logic [NUM_CH-1:0] clean_out,
    output logic [NUM_CH-1:0] press_out,
    output logic [NUM_CH-1:0] release_out
);

    localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [NUM_CH-1:0] sync1_q, sync1_d;
    logic [NUM_CH-1:0] sync2_q, sync2_d;
    logic [NUM_CH-1:0] cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] clean_q, clean_d;
    logic [NUM_CH-1:0] press_q, press_d;
    logic [NUM_CH-1:0] release_q, release_d;
    logic [NUM_CH-1:0] rise, fall;

    // cnt saturates at CNT_LAST once a level is accepted, so clean simply re-loads cand.
    always_comb begin
        sync1_d = noisy_in;
        sync2_d = sync1_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (sync2_q[ch] != cand_q[ch]) begin
                cand_d[ch] = sync2_q[ch];
                cnt_d[ch]  = '0;
            end else if (cnt_q[ch] == CNT_LAST) begin
                clean_d[ch] = cand_q[ch];
            end else begin
                cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
            end
        end
        rise      = clean_d & ~clean_q;
        fall      = ~clean_d & clean_q;
        release_d = fall;
    end

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PER_LAST = RPT_W'(REPEAT_PERIOD - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    logic [1:0]        state_q [NUM_CH];
    logic [1:0]        state_d [NUM_CH];
    logic [RPT_W-1:0]  rpt_q   [NUM_CH];
    logic [RPT_W-1:0]  rpt_d   [NUM_CH];
    logic [NUM_CH-1:0] rpt_fire;

    // A release wins over everything, so a coincident repeat expiry is dropped.
    always_comb begin
        state_d  = state_q;
        rpt_d    = rpt_q;
        rpt_fire = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (fall[ch]) begin
                state_d[ch] = ST_IDLE;
            end else begin
                case (state_q[ch])
                    ST_IDLE: begin
                        if (rise[ch]) begin
                            state_d[ch] = repeat_mask_in[ch] ? ST_DELAY : ST_HOLD;
                            rpt_d[ch]   = '0;
                        end
                    end
                    ST_DELAY: begin
                        if (!repeat_mask_in[ch]) begin
                            state_d[ch] = ST_HOLD;
                        end else if (rpt_q[ch] == RPT_DLY_LAST) begin
                            rpt_fire[ch] = 1'b1;
                            rpt_d[ch]    = '0;
                            state_d[ch]  = ST_REPEAT;
                        end else begin
                            rpt_d[ch] = rpt_q[ch] + RPT_W'(1);
                        end
                    end
                    ST_REPEAT: begin
                        if (!repeat_mask_in[ch]) begin
                            state_d[ch] = ST_HOLD;
                        end else if (rpt_q[ch] == RPT_PER_LAST) begin
                            rpt_fire[ch] = 1'b1;
                            rpt_d[ch]    = '0;
                        end else begin
                            rpt_d[ch] = rpt_q[ch] + RPT_W'(1);
                        end
                    end
                    ST_HOLD: begin
                        state_d[ch] = ST_HOLD;
                    end
                    default: begin
                        state_d[ch] = ST_IDLE;
                    end
                endcase
            end
        end
        press_d = rise | rpt_fire;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                state_q[ch] <= ST_IDLE;
                rpt_q[ch]   <= '0;
            end
        end else begin
            state_q <= state_d;
            rpt_q   <= rpt_d;
        end
    end
`else
    logic unused_repeat;
    assign unused_repeat = (^repeat_mask_in) ^ (REPEAT_DELAY == REPEAT_PERIOD);

    always_comb begin
        press_d = rise;
    end
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            cand_q    <= '0;
            clean_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                cnt_q[ch] <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            clean_q   <= clean_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign clean_out   = clean_q;
    assign press_out   = press_q;
    assign release_out = release_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed and randomized bench for button_conditioner against a time-stamp based reference model.
module tb_button_conditioner;

    localparam int NCH = 2;
    localparam int SC  = 4;
    localparam int RD  = 10;
    localparam int RP  = 3;

    logic           clk_in         = 1'b0;
    logic           rst_n_in       = 1'b0;
    logic [NCH-1:0] noisy_in       = '0;
    logic [NCH-1:0] repeat_mask_in = '0;
    logic [NCH-1:0] clean_out;
    logic [NCH-1:0] press_out;
    logic [NCH-1:0] release_out;

    button_conditioner #(
        .NUM_CH        (NCH),
        .STABLE_CYCLES (SC),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .noisy_in       (noisy_in),
        .repeat_mask_in (repeat_mask_in),
        .clean_out      (clean_out),
        .press_out      (press_out),
        .release_out    (release_out)
    );

    always #5 clk_in = ~clk_in;

    int tests = 0;
    int fails = 0;

    // Reference model: a level is accepted once the last SC+1 synchronised
    // samples (raw samples delayed two edges) agree; repeats are time-stamped.
    logic [SC+2:0]  hist [NCH];
    logic [NCH-1:0] m_clean, m_press, m_release;
    bit             held [NCH];
    bit             mok  [NCH];
    int             pt   [NCH];
    int             ecount = 0;

    task automatic model_reset();
        for (int ch = 0; ch < NCH; ch++) begin
            hist[ch] = '0;
            held[ch] = 1'b0;
            mok[ch]  = 1'b0;
            pt[ch]   = 0;
        end
        m_clean   = '0;
        m_press   = '0;
        m_release = '0;
    endtask

    task automatic model_edge();
        logic nc, rise, fall, rep;
        ecount++;
        if (!rst_n_in) return;
        for (int ch = 0; ch < NCH; ch++) begin
            hist[ch] = {hist[ch][SC+1:0], noisy_in[ch]};
            nc = m_clean[ch];
            if (&hist[ch][SC+2:2])       nc = 1'b1;
            else if (~|hist[ch][SC+2:2]) nc = 1'b0;
            rise = nc & ~m_clean[ch];
            fall = ~nc & m_clean[ch];
            if (rise) begin
                held[ch] = 1'b1;
                pt[ch]   = ecount;
                mok[ch]  = repeat_mask_in[ch];
            end else if (held[ch]) begin
                mok[ch] = mok[ch] & repeat_mask_in[ch];
            end
            if (fall) held[ch] = 1'b0;
            rep = 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
            if (held[ch] && !rise && mok[ch] && (ecount - pt[ch] >= RD) &&
                ((ecount - pt[ch] - RD) % RP == 0))
                rep = 1'b1;
`endif
            m_press[ch]   = rise | rep;
            m_release[ch] = fall;
            m_clean[ch]   = nc;
        end
    endtask

    task automatic chk(input string tag, input logic [NCH-1:0] got, input logic [NCH-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("clean", clean_out, m_clean);
        chk("press", press_out, m_press);
        chk("release", release_out, m_release);
    endtask

    task automatic step();
        @(posedge clk_in);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic step_quiet(input string tag);
        step();
        chk(tag, clean_out | press_out | release_out, 2'b00);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int cnt0, cnt1, exp_rpt;
        int rl [NCH];

        model_reset();
        repeat_mask_in = 2'b01;
        #12;
        chk("reset_clean", clean_out, 2'b00);
        chk("reset_press", press_out, 2'b00);
        chk("reset_release", release_out, 2'b00);
        repeat (2) step();
        rst_n_in = 1'b1;

        // Two 3-cycle glitches separated by 2 low cycles never get accepted.
        for (int r = 0; r < 2; r++) begin
            noisy_in = 2'b01;
            repeat (3) step_quiet("glitch");
            noisy_in = 2'b00;
            repeat (2) step_quiet("glitch");
        end
        repeat (8) step_quiet("glitch_tail");

        // Clean press on ch0 lands on the 7th edge.
        noisy_in = 2'b01;
        repeat (6) step();
        chk("press_before_e7", press_out, 2'b00);
        step();
        chk("press_e7", press_out, 2'b01);
        chk("clean_e7", clean_out, 2'b01);

        // Hold both; ch1 has repeat disabled.
        noisy_in = 2'b11;
        cnt0 = 0;
        cnt1 = 0;
        for (int d = 1; d <= 30; d++) begin
            step();
            cnt0 += int'(press_out[0]);
            cnt1 += int'(press_out[1]);
        end
`ifdef BUTTON_AUTOREPEAT_EN
        exp_rpt = 7;
`else
        exp_rpt = 0;
`endif
        chk_int("ch0_repeat_count", cnt0, exp_rpt);
        chk_int("ch1_press_count", cnt1, 1);

        // Release ch0 so acceptance lands on a repeat expiry (d=37).
        noisy_in = 2'b10;
        repeat (6) step();
        step();
        chk("release_on_expiry", release_out, 2'b01);
        chk("press_on_expiry", press_out, 2'b00);
        chk("clean_after_release", clean_out, 2'b10);
        cnt0 = 0;
        for (int d = 0; d < 12; d++) begin
            step();
            cnt0 += int'(press_out[0]);
        end
        chk_int("ch0_idle_after_release", cnt0, 0);

        // Mid-hold asynchronous reset, then ch1 held through reset.
        rst_n_in = 1'b0;
        model_reset();
        #1;
        chk("async_reset_clean", clean_out, 2'b00);
        chk("async_reset_release", release_out, 2'b00);
        repeat (2) step();
        rst_n_in = 1'b1;
        repeat (6) step();
        chk("held_reset_no_early_press", press_out, 2'b00);
        step();
        chk("held_reset_press_e7", press_out, 2'b10);
        chk("held_reset_clean_e7", clean_out, 2'b10);

        // Randomized run against the model.
        rl[0] = 0;
        rl[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (rl[ch] == 0) begin
                    noisy_in[ch] = ~noisy_in[ch];
                    rl[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 45))
                                                         : int'($urandom_range(1, 8));
                end else begin
                    rl[ch]--;
                end
                if ($urandom_range(0, 31) == 0) repeat_mask_in[ch] = ~repeat_mask_in[ch];
            end
            if (rst_n_in && $urandom_range(0, 599) == 0) begin
                rst_n_in = 1'b0;
                model_reset();
                #1;
                check_model();
            end else if (!rst_n_in) begin
                rst_n_in = 1'b1;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
